// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, address-split, cache-frame and dcache FSM types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int FTAG_W = 29;
  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;
  // Frame tag is wide enough for any SETS >= 1; unused upper bits stay zero.
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [FTAG_W-1:0] tag;
    word_t [1:0]       data;
  } dcache_frame;
  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FLUSH_WB0, FLUSH_WB1, DONE
  } dstate_t;
  function automatic logic [FTAG_W-1:0] tag_of(word_t a, int unsigned ib);
    return FTAG_W'(a >> (3 + ib));
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: datapath-side and memory-controller-side bundles of the data cache.
interface datapath_cache_if;
  import cpu_types_pkg::*;
  logic  dmemREN, dmemWEN, halt, dhit, flushed;
  word_t dmemaddr, dmemstore, dmemload;
  modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, input dhit, dmemload, flushed);
  modport slave (input dmemREN, dmemWEN, dmemaddr, dmemstore, halt, output dhit, dmemload, flushed);
endinterface

interface cache_control_if;
  import cpu_types_pkg::*;
  logic  dREN, dWEN, dwait;
  word_t daddr, dstore, dload;
  modport master (output dREN, dWEN, daddr, dstore, input dload, dwait);
  modport slave (input dREN, dWEN, daddr, dstore, output dload, dwait);
endinterface

// File: rtl/dcache.sv
// dcache: 2-way set-associative write-back, write-allocate data cache with halt flush.
module dcache
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int CPUID = 0
) (
  input logic                    CLK,
  input logic                    RST,
  datapath_cache_if.slave        dcif,
  cache_control_if.master        cif
);
  localparam int IB = $clog2(SETS);
  dcache_frame       frames_q [SETS][WAYS];
  dcache_frame       frames_d [SETS][WAYS];
  logic [SETS-1:0]   lru_q, lru_d;
  dstate_t           state_q, state_d;
  logic [IB:0]       fidx_q, fidx_d;
  logic              victim_q, victim_d;
  word_t             ld0_q, ld0_d;
  logic [IB-1:0]     idx, fset;
  logic [FTAG_W-1:0] tag;
  logic [1:0]        hitv;
  logic              hway, hit, req, blk, fway, last;
  dcache_frame       vf, ff;
  always_comb begin
    idx  = dcif.dmemaddr[2+IB:3];
    blk  = dcif.dmemaddr[2];
    tag  = tag_of(dcif.dmemaddr, IB);
    for (int w = 0; w < 2; w++) hitv[w] = frames_q[idx][w].valid && frames_q[idx][w].tag == tag;
    hit  = |hitv;
    hway = hitv[1];
    req  = dcif.dmemREN || dcif.dmemWEN;
    vf   = frames_q[idx][victim_q];
    fset = fidx_q[IB:1];
    fway = fidx_q[0];
    ff   = frames_q[fset][fway];
    last = &fidx_q;
    dcif.dhit     = state_q == IDLE && !dcif.halt && req && hit;
    dcif.dmemload = dcif.dhit ? frames_q[idx][hway].data[blk] : '0;
    dcif.flushed  = state_q == DONE;
  end
  always_comb begin
    state_d    = state_q;
    frames_d   = frames_q;
    lru_d      = lru_q;
    fidx_d     = fidx_q;
    victim_d   = victim_q;
    ld0_d      = ld0_q;
    cif.dREN   = 1'b0;
    cif.dWEN   = 1'b0;
    cif.daddr  = '0;
    cif.dstore = '0;
    case (state_q)
      IDLE: begin
        if (dcif.halt) begin
          state_d = FLUSH;
          fidx_d  = '0;
        end else if (dcif.dhit) begin
          lru_d[idx] = !hway;
          if (dcif.dmemWEN) begin
            frames_d[idx][hway].data[blk] = dcif.dmemstore;
            frames_d[idx][hway].dirty     = 1'b1;
          end
        end else if (req) begin
          victim_d = !frames_q[idx][0].valid ? 1'b0 : !frames_q[idx][1].valid ? 1'b1 : lru_q[idx];
          state_d  = frames_q[idx][victim_d].dirty ? WB0 : LD0;
        end
      end
      WB0, WB1: begin
        cif.dWEN   = 1'b1;
        cif.daddr  = word_t'({vf.tag, idx, state_q == WB1, 2'b00});
        cif.dstore = vf.data[state_q == WB1];
        if (!cif.dwait) state_d = state_q == WB0 ? WB1 : LD0;
      end
      LD0, LD1: begin
        cif.dREN  = 1'b1;
        cif.daddr = {dcif.dmemaddr[31:3], state_q == LD1, 2'b00};
        if (!cif.dwait) begin
          ld0_d   = state_q == LD0 ? cif.dload : ld0_q;
          state_d = state_q == LD0 ? LD1 : IDLE;
          if (state_q == LD1) begin
            frames_d[idx][victim_q].valid = 1'b1;
            frames_d[idx][victim_q].dirty = 1'b0;
            frames_d[idx][victim_q].tag   = tag;
            frames_d[idx][victim_q].data  = {cif.dload, ld0_q};
          end
        end
      end
      FLUSH: begin
        state_d = ff.dirty ? FLUSH_WB0 : last ? DONE : FLUSH;
        fidx_d  = ff.dirty ? fidx_q : fidx_q + 1'b1;
      end
      FLUSH_WB0, FLUSH_WB1: begin
        cif.dWEN   = 1'b1;
        cif.daddr  = word_t'({ff.tag, fset, state_q == FLUSH_WB1, 2'b00});
        cif.dstore = ff.data[state_q == FLUSH_WB1];
        if (!cif.dwait && state_q == FLUSH_WB0) state_d = FLUSH_WB1;
        if (!cif.dwait && state_q == FLUSH_WB1) begin
          frames_d[fset][fway].dirty = 1'b0;
          state_d = last ? DONE : FLUSH;
          fidx_d  = fidx_q + 1'b1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      frames_q <= '{default: '0};
      lru_q    <= '0;
      fidx_q   <= '0;
      victim_q <= 1'b0;
      ld0_q    <= '0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      lru_q    <= lru_d;
      fidx_q   <= fidx_d;
      victim_q <= victim_d;
      ld0_q    <= ld0_d;
    end
  end
  a_excl: assert property (@(posedge CLK) disable iff (RST) !(cif.dREN && cif.dWEN))
    else $error("dcache cpu%0d: dREN and dWEN both high", CPUID);
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed and randomized checks of dcache against a block-level cache/memory model.
module tb_dcache;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  datapath_cache_if dcif();
  cache_control_if  cif();
  dcache #(.SETS(8), .WAYS(2), .CPUID(0)) dut (.CLK(CLK), .RST(RST), .dcif(dcif.slave), .cif(cif.master));
  always #5 CLK = ~CLK;

  word_t mem [128];
  word_t ref_mem [128];
  bit    mem_ready;
  int    wcnt, lat_lo = 1, lat_hi = 1;
  word_t wa_log[$], wd_log[$], ra_log[$];
  int    checks, errors;
  int    q [8][$];
  bit    dirty [64];

  function automatic word_t init_val(int i);
    return i == 2 ? 32'h11111111 : i == 3 ? 32'h22222222 : (word_t'(i) * 32'h01010101) ^ 32'h5A000000;
  endfunction

  assign cif.dload = mem[cif.daddr[8:2]];
  assign cif.dwait = (cif.dREN || cif.dWEN) && wcnt != 0;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (!(cif.dREN || cif.dWEN)) wcnt <= $urandom_range(lat_hi, lat_lo);
    else if (wcnt != 0) wcnt <= wcnt - 1;
    else begin
      if (cif.dWEN) begin
        mem[cif.daddr[8:2]] <= cif.dstore;
        wa_log.push_back(cif.daddr);
        wd_log.push_back(cif.dstore);
      end else ra_log.push_back(cif.daddr);
      wcnt <= $urandom_range(lat_hi, lat_lo);
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    dcif.halt = 1'b0;
    dcif.dmemREN = 1'b0;
    dcif.dmemWEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int s = 0; s < 8; s++) q[s].delete();
    for (int b = 0; b < 64; b++) dirty[b] = 1'b0;
  endtask

  task automatic access(input word_t a, input logic w, input word_t d, output int cyc, output logic ok, output word_t got);
    dcif.dmemaddr = a;
    dcif.dmemREN = !w;
    dcif.dmemWEN = w;
    dcif.dmemstore = d;
    cyc = 0;
    #1;
    while (!dcif.dhit && cyc < 300) begin
      @(posedge CLK);
      #1 cyc++;
    end
    ok = dcif.dhit;
    got = dcif.dmemload;
    @(posedge CLK);
    #1 dcif.dmemREN = 1'b0;
    dcif.dmemWEN = 1'b0;
  endtask

  // One request checked against the model: hit/miss, returned data, exact fill and write-back traffic.
  task automatic step(input word_t a, input logic w, input word_t d, output int cyc);
    int b, s, nr, nw, ev;
    bit hit, evd;
    logic ok;
    word_t got, exp;
    b = int'(a >> 3); s = b % 8; hit = 0; evd = 0; ev = 0; exp = ref_mem[a[8:2]];
    for (int i = 0; i < q[s].size(); i++) if (q[s][i] == b) begin
      hit = 1;
      q[s].delete(i);
      break;
    end
    if (!hit && q[s].size() == 2) begin
      ev = q[s].pop_front();
      evd = dirty[ev];
      dirty[ev] = 1'b0;
    end
    q[s].push_back(b);
    nr = ra_log.size(); nw = wa_log.size();
    access(a, w, d, cyc, ok, got);
    chk($sformatf("served@%h", a), ok, 1);
    chk($sformatf("hit@%h", a), cyc == 0, hit);
    if (!w) chk($sformatf("load@%h", a), got, exp);
    chk($sformatf("reads@%h", a), ra_log.size() - nr, hit ? 0 : 2);
    chk($sformatf("writes@%h", a), wa_log.size() - nw, evd ? 2 : 0);
    if (!hit && ra_log.size() >= nr + 2) begin
      chk("fill addr0", ra_log[nr], word_t'(b * 8));
      chk("fill addr1", ra_log[nr+1], word_t'(b * 8 + 4));
    end
    if (evd && wa_log.size() >= nw + 2) for (int k = 0; k < 2; k++) begin
      chk("wb addr", wa_log[nw+k], word_t'(ev * 8 + 4 * k));
      chk("wb data", wd_log[nw+k], ref_mem[ev*2+k]);
    end
    if (w) begin
      ref_mem[a[8:2]] = d;
      dirty[b] = 1'b1;
    end
  endtask

  task automatic do_flush();
    int nw, cyc, nd;
    nd = 0;
    for (int b = 0; b < 64; b++) nd += int'(dirty[b]);
    nw = wa_log.size(); cyc = 0;
    dcif.dmemaddr = 32'h08;
    dcif.dmemREN = 1'b1;
    dcif.halt = 1'b1;
    #1 chk("halt wins", dcif.dhit, 0);
    dcif.dmemREN = 1'b0;
    while (!dcif.flushed && cyc < 2000) begin
      @(posedge CLK);
      #1 cyc++;
    end
    chk("flushed", dcif.flushed, 1);
    chk("flush writes", wa_log.size() - nw, 2 * nd);
    chk("done dREN", cif.dREN, 0);
    chk("done dWEN", cif.dWEN, 0);
    dcif.dmemREN = 1'b1;
    #1 chk("no serve after done", dcif.dhit, 0);
    dcif.dmemREN = 1'b0;
    for (int i = 0; i < 128; i++) chk($sformatf("mem[%h]", i * 4), mem[i], ref_mem[i]);
    for (int b = 0; b < 64; b++) dirty[b] = 1'b0;
  endtask

  initial begin
    int cyc, nw;
    dcif.dmemREN = 1'b0;
    dcif.dmemWEN = 1'b0;
    dcif.halt = 1'b0;
    dcif.dmemaddr = '0;
    dcif.dmemstore = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    do_reset();
    chk("rst dhit", dcif.dhit, 0);
    chk("rst flushed", dcif.flushed, 0);
    chk("rst dREN", cif.dREN, 0);
    chk("rst dWEN", cif.dWEN, 0);
    chk("rst daddr", cif.daddr, 0);
    chk("rst dstore", cif.dstore, 0);
    chk("rst dmemload", dcif.dmemload, 0);
    do_flush();
    do_reset();
    step(32'h08, 0, 0, cyc);
    chk("miss latency>=4", cyc >= 4, 1);
    step(32'h0C, 0, 0, cyc);
    step(32'h3C, 0, 0, cyc);
    step(32'h3C, 0, 0, cyc);
    step(32'h00, 0, 0, cyc);
    step(32'h00, 0, 0, cyc);
    step(32'h08, 1, 32'hBEEFDEAD, cyc);
    step(32'h08, 0, 0, cyc);
    step(32'h48, 0, 0, cyc);
    step(32'h88, 0, 0, cyc);
    step(32'h48, 0, 0, cyc);
    step(32'h08, 1, 32'hCAFE0008, cyc);
    step(32'h3C, 1, 32'hCAFE003C, cyc);
    nw = wa_log.size();
    do_flush();
    if (wa_log.size() >= nw + 4) begin
      chk("flush a0", wa_log[nw], 32'h08);
      chk("flush a1", wa_log[nw+1], 32'h0C);
      chk("flush a2", wa_log[nw+2], 32'h38);
      chk("flush a3", wa_log[nw+3], 32'h3C);
    end
    do_reset();
    lat_lo = 0; lat_hi = 2;
    repeat (250) begin
      word_t a;
      logic w;
      a = word_t'($urandom_range(127, 0)) << 2;
      w = 1'($urandom_range(1, 0));
      step(a, w, $urandom, cyc);
    end
    do_flush();
    do_reset();
    lat_lo = 2; lat_hi = 2;
    dcif.dmemaddr = 32'h100;
    dcif.dmemREN = 1'b1;
    cyc = 0;
    while (!cif.dREN && cyc < 20) begin
      @(posedge CLK);
      #1 cyc++;
    end
    chk("fill started", cif.dREN, 1);
    RST = 1'b1;
    dcif.dmemREN = 1'b0;
    @(posedge CLK);
    #1 chk("abort dREN", cif.dREN, 0);
    chk("abort dWEN", cif.dWEN, 0);
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
